mpu_det_seq: RTL
================

// Module: mpu_det_seq
// PURPOSE
//  Sequential, parametrised NxN determinant unit for the MPU (N = 1..MAX_N).
//  Evaluates the exact Leibniz expansion, one permutation term per clock,
//  into a full-width accumulator. Reports the full result, a saturated
//  RES_W result and overflow. Sits beside the other MPU ops behind a
//  start/done handshake.
// PARAMETERS
//  MAX_N   5   largest supported matrix order
//  DATA_W  8   signed element width
//  RES_W   8   signed width of the saturated result
//  ACC_W   MAX_N*DATA_W+clog2(MAX_N!)  full accumulator width (47 at defaults), derived
// PORTS
//  clock     in   1                    rising-edge clock
//  reset     in   1                    asynchronous, active-high reset
//  start     in   1                    request; sampled only while busy=0
//  matrix    in   DATA_W*MAX_N*MAX_N   element(r,c) at [DATA_W*(c+MAX_N*r) +: DATA_W], signed
//  size      in   8                    matrix order N, unsigned
//  busy      out  1                    operation in progress
//  done      out  1                    one-cycle completion pulse
//  result    out  RES_W                signed determinant, saturated
//  det_full  out  ACC_W                signed exact determinant
//  overflow  out  1                    1 = result was clamped
//  error     out  1                    1 = size was 0 or > MAX_N
// BEHAVIOUR
//  - Reset: FSM=IDLE; busy, done, overflow, error = 0; result, det_full = 0.
//    Reset mid-operation aborts the run. No done pulse follows.
//  - start=1 in IDLE at edge E0 latches matrix and size and clears the accumulator.
//    start while busy is ignored. matrix and size may change after E0.
//  - States:
//    - IDLE -> RUN: valid size.
//    - IDLE -> ERR: size=0 or size>MAX_N.
//    - RUN -> DRAIN: after N! terms issued.
//    - DRAIN -> FIN: after 2 cycles.
//    - FIN -> IDLE and ERR -> IDLE: 1 cycle each.
//  - busy is 1 from E0 until done rises, and falls on the same edge.
//  - done=1 for exactly one cycle:
//    - valid size: after edge E0+N!+3;
//    - ERR: after edge E0+1, with error=1, result=0, det_full=0, overflow=0.
//  - Permutation generation: iterative Heap's algorithm, one transposition per
//    cycle.
//    - Find the lowest i>=1 with c[i]<i, clear c[1..i-1], increment c[i].
//    - Swap perm[0],perm[i] if i is even, else perm[c[i]],perm[i].
//    - perm starts as identity. Term k (k=0..N!-1) has sign (-1)^k.
//  - Term pipeline:
//    - stage 1 registers prod = PRODUCT r<N of element(r,perm[r]);
//    - stage 2 does acc += sign ? -prod : prod.
//    - All arithmetic is signed at ACC_W, sign-extended before multiplying, so it
//      never wraps internally.
//  - Rows and columns >= N are never read.
//  - N=1: det = element(0,0).
//  - At FIN:
//    - det_full = acc.
//    - result = clamp(acc, -2^(RES_W-1), 2^(RES_W-1)-1).
//    - overflow = 1 iff clamped.
//  - Outputs hold until the next accepted start. error clears at the next
//    accepted start.
// STRUCTURE
//  - Package mpu_pkg:
//    - MAX_N and DATA_W defaults;
//    - constant function fact(n);
//    - ACC_W derivation;
//    - clog2;
//    - det_state_t enum {IDLE,RUN,DRAIN,FIN,ERR};
//    - element-index function at(r,c).
//  - Sub-module mpu_perm_gen (Heap's generator).
//    - Inputs: clock, reset, init, step, n.
//    - Outputs: perm[MAX_N] of clog2(MAX_N) bits, parity, last.
//  - Top: FSM, term counter, product and accumulate stages, saturation.
// TESTING
//  1. N=2, [[3,4],[2,5]] -> det_full=7, result=7, overflow=0, done at E0+5, busy high for 5 cycles.
//  2. N=3, [[6,1,1],[4,-2,5],[2,8,7]] -> det_full=-306, result=-128, overflow=1, done at E0+9.
//  3. N=5, diag(2,2,2,2,2) -> 32. Same matrix with rows 0 and 1 swapped -> -32. done at E0+123.
//  4. N=1, element(0,0)=-128 -> result=-128, overflow=0, done at E0+4.
//  5. size=0, then size=6 -> error=1, result=0, done at E0+1. Next valid start clears error.
//  6. N=4, start held high through the run plus a second start at E0+10 -> single done, second start ignored.
//     Reset at E0+10 of a fresh run -> busy=0 and outputs 0 immediately, no done.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared types, defaults and constant helpers for the MPU determinant unit.
package mpu_pkg;

  localparam int MAX_N_DEF  = 5;
  localparam int DATA_W_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  function automatic int fact(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Width of an index that selects one of `count` entries; never narrower than one bit.
  function automatic int sel_w(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

  // Product of max_n elements plus growth from summing max_n! terms.
  function automatic int acc_w(input int max_n, input int data_w);
    return max_n * data_w + clog2(fact(max_n));
  endfunction

  localparam int ACC_W_DEF = acc_w(MAX_N_DEF, DATA_W_DEF);

  function automatic int at(input int r, input int c, input int max_n = MAX_N_DEF);
    return c + max_n * r;
  endfunction

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FIN, ERR} det_state_t;

endpackage

// File: rtl/mpu_perm_gen.sv
// Iterative Heap's-algorithm permutation generator: one transposition per step,
// with running parity and a flag marking the final permutation of order n.
module mpu_perm_gen
  import mpu_pkg::*;
#(
  parameter int MAX_N = MAX_N_DEF,
  parameter int IDX_W = sel_w(MAX_N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             step,
  input  logic [7:0]       n,
  output logic [IDX_W-1:0] perm [MAX_N],
  output logic             parity,
  output logic             last
);

  logic [IDX_W-1:0] perm_q [MAX_N];
  logic [IDX_W-1:0] perm_d [MAX_N];
  logic [IDX_W-1:0] c_q    [MAX_N];
  logic [IDX_W-1:0] c_d    [MAX_N];
  logic             par_q, par_d;
  logic             found;
  logic [IDX_W-1:0] sel, swp;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned (no latch).
    perm_d = perm_q;
    c_d    = c_q;
    par_d  = par_q;
    found  = 1'b0;
    sel    = '0;
    swp    = '0;

    for (int i = 1; i < MAX_N; i++) begin
      if (!found && i < int'(n) && int'(c_q[i]) < i) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end

    if (init) begin
      for (int i = 0; i < MAX_N; i++) begin
        perm_d[i] = IDX_W'(i);
        c_d[i]    = '0;
      end
      par_d = 1'b0;
    end else if (step && found) begin
      for (int i = 1; i < MAX_N; i++) begin
        if (i < int'(sel)) c_d[i] = '0;
      end
      c_d[sel] = c_q[sel] + IDX_W'(1);
      // Odd position swaps with its counter slot (pre-increment), even with slot 0.
      swp          = sel[0] ? c_q[sel] : '0;
      perm_d[swp]  = perm_q[sel];
      perm_d[sel]  = perm_q[swp];
      par_d        = ~par_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_N; i++) begin
        perm_q[i] <= IDX_W'(i);
        c_q[i]    <= '0;
      end
      par_q <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
      perm_q <= perm_d;
      c_q    <= c_d;
      par_q  <= par_d;
    end
  end

  assign perm   = perm_q;
  assign parity = par_q;
  assign last   = ~found;

endmodule

// File: rtl/mpu_det_seq.sv
// Sequential NxN determinant: Leibniz expansion, one signed permutation term per
// clock through a product stage and an accumulate stage, then saturation to RES_W.
module mpu_det_seq
  import mpu_pkg::*;
#(
  parameter int MAX_N  = MAX_N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = 8,
  parameter int ACC_W  = acc_w(MAX_N, DATA_W)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DATA_W*MAX_N*MAX_N-1:0]   matrix,
  input  logic [7:0]                      size,
  output logic                            busy,
  output logic                            done,
  output logic signed [RES_W-1:0]         result,
  output logic signed [ACC_W-1:0]         det_full,
  output logic                            overflow,
  output logic                            error
);

  localparam int IDX_W  = sel_w(MAX_N);
  localparam int TERM_W = sel_w(fact(MAX_N));
  localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((1 <<< (RES_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] RES_MIN = ACC_W'(-(1 <<< (RES_W - 1)));

  det_state_t                      state_q, state_d;
  logic [DATA_W*MAX_N*MAX_N-1:0]   mat_q, mat_d;
  logic [7:0]                      n_q, n_d;
  logic [TERM_W-1:0]               term_q, term_d, last_q, last_d;
  logic                            drain_q, drain_d;
  logic signed [ACC_W-1:0]         prod_q, prod_d, acc_q, acc_d, det_q, det_d;
  logic                            neg_q, neg_d, vld_q, vld_d;
  logic                            busy_q, busy_d, done_q, done_d;
  logic                            ovf_q, ovf_d, err_q, err_d;
  logic signed [RES_W-1:0]         res_q, res_d;

  logic                            accept;
  logic [IDX_W-1:0]                perm [MAX_N];
  logic                            perm_par, perm_last;
  logic signed [DATA_W-1:0]        elem;
  logic signed [ACC_W-1:0]         ext, prod;
  logic                            sat_hi, sat_lo;

  assign accept = (state_q == IDLE) && start;

  mpu_perm_gen #(.MAX_N(MAX_N), .IDX_W(IDX_W)) u_perm (
    .clock  (clock),
    .reset  (reset),
    .init   (accept),
    .step   (state_q == RUN),
    .n      (n_q),
    .perm   (perm),
    .parity (perm_par),
    .last   (perm_last)
  );

  // Rows at or beyond the latched order contribute a factor of one and are never read.
  always_comb begin
    prod = ACC_W'(1);
    elem = '0;
    ext  = '0;
    for (int r = 0; r < MAX_N; r++) begin
      if (r < int'(n_q)) begin
        elem = mat_q[DATA_W*at(r, int'(perm[r]), MAX_N) +: DATA_W];
        ext  = {{(ACC_W-DATA_W){elem[DATA_W-1]}}, elem};
        prod = prod * ext;
      end
    end
  end

  assign sat_hi = acc_q > RES_MAX;
  assign sat_lo = acc_q < RES_MIN;

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    n_d     = n_q;
    term_d  = term_q;
    last_d  = last_q;
    drain_d = drain_q;
    prod_d  = prod_q;
    neg_d   = neg_q;
    vld_d   = 1'b0;
    acc_d   = vld_q ? (neg_q ? acc_q - prod_q : acc_q + prod_q) : acc_q;
    det_d   = det_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mat_d   = matrix;
          n_d     = size;
          acc_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          term_d  = '0;
          drain_d = 1'b0;
          last_d  = '0;
          for (int k = 1; k <= MAX_N; k++) begin
            if (int'(size) == k) last_d = TERM_W'(fact(k) - 1);
          end
          state_d = (size != 8'd0 && int'(size) <= MAX_N) ? RUN : ERR;
        end
      end
      RUN: begin
        prod_d = prod;
        neg_d  = perm_par;
        vld_d  = 1'b1;
        term_d = term_q + TERM_W'(1);
        if (term_q == last_q || perm_last) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = FIN;
      end
      FIN: begin
        det_d   = acc_q;
        res_d   = sat_hi ? RES_MAX[RES_W-1:0] : (sat_lo ? RES_MIN[RES_W-1:0] : acc_q[RES_W-1:0]);
        ovf_d   = sat_hi | sat_lo;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        det_d   = '0;
        res_d   = '0;
        ovf_d   = 1'b0;
        err_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      term_q  <= '0;
      last_q  <= '0;
      drain_q <= 1'b0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      vld_q   <= 1'b0;
      acc_q   <= '0;
      det_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      term_q  <= term_d;
      last_q  <= last_d;
      drain_q <= drain_d;
      prod_q  <= prod_d;
      neg_q   <= neg_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      det_q   <= det_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the matrix store is pure data qualified by state, so it carries no reset.
  always_ff @(posedge clock) begin
    mat_q <= mat_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = res_q;
  assign det_full = det_q;
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule
